triangle_bbox_stage: RTL and testbench

//  Consumes the triangle stream fetched by the rasterization controller (valid-only, no backpressure).

---
 rtl/triangle_bbox_stage_pkg.sv | 45 ++++
 rtl/triangle_bbox_stage_if.sv | 13 +
 rtl/triangle_bbox_stage_tri_fifo.sv | 57 +++++
 rtl/triangle_bbox_stage.sv | 157 +++++++++++++++
 tb/tb_triangle_bbox_stage.sv | 305 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/triangle_bbox_stage_pkg.sv
// Shared types for the triangle bounding-box stage: signed screen-space vertices, triangle, clamped box.
// Box edges are unsigned because they are always clamped onto the screen before leaving the stage.
package triangle_bbox_stage_pkg;
    localparam int COORD_W  = 12;
    localparam int AREA_W   = 2*COORD_W + 2;
    localparam int SCREEN_W = 320;
    localparam int SCREEN_H = 240;

    typedef logic signed [COORD_W-1:0] coord_t;
    typedef logic [COORD_W-1:0]        ucoord_t;

    typedef struct packed {
        coord_t x;
        coord_t y;
    } Vertex;

    typedef struct packed {
        Vertex [2:0] v;
    } Triangle;

    typedef struct packed {
        ucoord_t xmin;
        ucoord_t xmax;
        ucoord_t ymin;
        ucoord_t ymax;
    } BBox;

    function automatic coord_t min3(input coord_t a, input coord_t b, input coord_t c);
        coord_t m;
        m = (a < b) ? a : b;
        return (c < m) ? c : m;
    endfunction

    function automatic coord_t max3(input coord_t a, input coord_t b, input coord_t c);
        coord_t m;
        m = (a > b) ? a : b;
        return (c > m) ? c : m;
    endfunction

    function automatic ucoord_t clamp_coord(input coord_t c, input coord_t hi);
        if (c < 0)  return '0;
        if (c > hi) return ucoord_t'(hi);
        return ucoord_t'(c);
    endfunction
endpackage

// File: rtl/triangle_bbox_stage_if.sv
// Bounding-box output bus towards the pixel iterator: valid/ready with the triangle carried beside its box.
// master drives the beat, slave returns ready.
interface triangle_bbox_stage_if;
    import triangle_bbox_stage_pkg::*;

    logic    bbox_valid;
    logic    bbox_ready;
    Triangle bbox_tri;
    BBox     bbox;

    modport master (output bbox_valid, output bbox_tri, output bbox, input bbox_ready);
    modport slave  (input bbox_valid, input bbox_tri, input bbox, output bbox_ready);
endinterface

// File: rtl/triangle_bbox_stage_tri_fifo.sv
// Generic synchronous FIFO with show-ahead head, fill count and synchronous flush.
// Latency: a push is visible at the head one edge later; push and pop may share a cycle, even when full.
// Backpressure: a push while full without a pop is ignored; the owner decides how to report it.
module tri_fifo #(
    parameter type T     = logic,
    parameter int  DEPTH = 8,
    localparam int CNT_W = $clog2(DEPTH + 1),
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush_i,
    input  logic             push_i,
    input  logic             pop_i,
    input  T                 push_dat_i,
    output T                 head_dat_o,
    output logic [CNT_W-1:0] count_o,
    output logic             full_o,
    output logic             empty_o
);
    T                 mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
    logic [CNT_W-1:0] count_q;
    logic             wr_en, rd_en;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign empty_o    = (count_q == '0);
    assign full_o     = (count_q == CNT_W'(DEPTH));
    assign rd_en      = pop_i && !empty_o && !flush_i;
    // A pop frees the head slot this cycle, so a full FIFO can still take a push.
    assign wr_en      = push_i && !flush_i && (!full_o || rd_en);
    assign head_dat_o = mem[rd_ptr_q];
    assign count_o    = count_q;

    always_ff @(posedge clk) begin
        if (wr_en) mem[wr_ptr_q] <= push_dat_i;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else if (flush_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (wr_en) wr_ptr_q <= ptr_inc(wr_ptr_q);
            if (rd_en) rd_ptr_q <= ptr_inc(rd_ptr_q);
            count_q <= count_q + CNT_W'(wr_en) - CNT_W'(rd_en);
        end
    end
endmodule

// File: rtl/triangle_bbox_stage.sv
// Triangle bbox stage: FIFO -> S1 min/max -> S2 clamp/drop -> output reg; BACKFACE_CULL_EN also drops area2<=0.
// Latency: a write at edge t reaches the output register at edge t+3; 1 triangle/cycle sustained.
// Backpressure: output holds while bbox_ready=0; input is credit-style via space_ready_o, overflowing writes drop.
module triangle_bbox_stage
    import triangle_bbox_stage_pkg::Triangle, triangle_bbox_stage_pkg::BBox,
           triangle_bbox_stage_pkg::coord_t, triangle_bbox_stage_pkg::min3,
           triangle_bbox_stage_pkg::max3, triangle_bbox_stage_pkg::clamp_coord;
#(
    parameter int  FIFO_DEPTH = 8,
    parameter int  INFLIGHT   = 2,
    parameter int  SCREEN_W   = triangle_bbox_stage_pkg::SCREEN_W,
    parameter int  SCREEN_H   = triangle_bbox_stage_pkg::SCREEN_H,
    localparam int OCC_W      = $clog2(FIFO_DEPTH + 1)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  flush_i,
    input  logic                  tri_in_valid_i,
    input  Triangle               tri_in_i,
    output logic                  space_ready_o,
    triangle_bbox_stage_if.master bbox_if,
    output logic [OCC_W-1:0]      occupancy_o,
    output logic                  overflow_o,
    output logic [15:0]           drop_count_o
);
    localparam coord_t XHI = coord_t'(SCREEN_W - 1);
    localparam coord_t YHI = coord_t'(SCREEN_H - 1);

    Triangle          head_dat;
    logic [OCC_W-1:0] count;
    logic             fifo_full, fifo_empty;
    logic             push, pop, out_adv, s2_rdy, s1_rdy, keep;

    logic             s1_vld_q;
    Triangle          s1_tri_q;
    coord_t           s1_xmin_q, s1_xmax_q, s1_ymin_q, s1_ymax_q;
    logic             s2_vld_q;
    Triangle          s2_tri_q;
    BBox              s2_box_q, s2_box_d;
    logic             out_vld_q;
    Triangle          out_tri_q;
    BBox              out_box_q;
    logic             overflow_q;
    logic [15:0]      drop_cnt_q;

    // Each stage loads when the one after it is empty or moving, so bubbles collapse.
    assign out_adv = !out_vld_q || bbox_if.bbox_ready;
    assign s2_rdy  = !s2_vld_q || out_adv;
    assign s1_rdy  = !s1_vld_q || s2_rdy;
    assign pop     = s1_rdy && !fifo_empty && !flush_i;
    assign push    = tri_in_valid_i && !flush_i;

    tri_fifo #(.T(Triangle), .DEPTH(FIFO_DEPTH)) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .flush_i   (flush_i),
        .push_i    (push),
        .pop_i     (pop),
        .push_dat_i(tri_in_i),
        .head_dat_o(head_dat),
        .count_o   (count),
        .full_o    (fifo_full),
        .empty_o   (fifo_empty)
    );

    // Same-cycle pops are ignored here; upstream sees a conservative credit.
    assign space_ready_o = (FIFO_DEPTH - int'(count)) >= (INFLIGHT + 1);

`ifdef BACKFACE_CULL_EN
    localparam int AW = triangle_bbox_stage_pkg::AREA_W;
    logic signed [AW-1:0] dx1, dy1, dx2, dy2, area_d, s1_area_q;
    always_comb begin
        dx1    = AW'($signed(head_dat.v[1].x)) - AW'($signed(head_dat.v[0].x));
        dy1    = AW'($signed(head_dat.v[1].y)) - AW'($signed(head_dat.v[0].y));
        dx2    = AW'($signed(head_dat.v[2].x)) - AW'($signed(head_dat.v[0].x));
        dy2    = AW'($signed(head_dat.v[2].y)) - AW'($signed(head_dat.v[0].y));
        area_d = dx1 * dy2 - dx2 * dy1;
    end
`endif

    always_comb begin
        keep = !(s1_xmax_q < 0 || s1_xmin_q > XHI || s1_ymax_q < 0 || s1_ymin_q > YHI);
`ifdef BACKFACE_CULL_EN
        // Non-positive area covers clockwise and degenerate triangles alike.
        if (s1_area_q <= 0) keep = 1'b0;
`endif
        s2_box_d.xmin = clamp_coord(s1_xmin_q, XHI);
        s2_box_d.xmax = clamp_coord(s1_xmax_q, XHI);
        s2_box_d.ymin = clamp_coord(s1_ymin_q, YHI);
        s2_box_d.ymax = clamp_coord(s1_ymax_q, YHI);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_vld_q   <= 1'b0;
            s1_tri_q   <= '0;
            s1_xmin_q  <= '0;
            s1_xmax_q  <= '0;
            s1_ymin_q  <= '0;
            s1_ymax_q  <= '0;
            s2_vld_q   <= 1'b0;
            s2_tri_q   <= '0;
            s2_box_q   <= '0;
            out_vld_q  <= 1'b0;
            out_tri_q  <= '0;
            out_box_q  <= '0;
            overflow_q <= 1'b0;
            drop_cnt_q <= '0;
        end else if (flush_i) begin
            s1_vld_q   <= 1'b0;
            s2_vld_q   <= 1'b0;
            out_vld_q  <= 1'b0;
            overflow_q <= 1'b0;
        end else begin
            if (push && fifo_full && !pop) overflow_q <= 1'b1;
            if (s1_rdy) begin
                s1_vld_q <= pop;
                if (pop) begin
                    s1_tri_q  <= head_dat;
                    s1_xmin_q <= min3(head_dat.v[0].x, head_dat.v[1].x, head_dat.v[2].x);
                    s1_xmax_q <= max3(head_dat.v[0].x, head_dat.v[1].x, head_dat.v[2].x);
                    s1_ymin_q <= min3(head_dat.v[0].y, head_dat.v[1].y, head_dat.v[2].y);
                    s1_ymax_q <= max3(head_dat.v[0].y, head_dat.v[1].y, head_dat.v[2].y);
                end
            end
            if (s2_rdy) begin
                s2_vld_q <= s1_vld_q && keep;
                if (s1_vld_q) begin
                    s2_tri_q <= s1_tri_q;
                    s2_box_q <= s2_box_d;
                end
                if (s1_vld_q && !keep && drop_cnt_q != 16'hFFFF) drop_cnt_q <= drop_cnt_q + 16'd1;
            end
            if (out_adv) begin
                out_vld_q <= s2_vld_q;
                if (s2_vld_q) begin
                    out_tri_q <= s2_tri_q;
                    out_box_q <= s2_box_q;
                end
            end
        end
    end

`ifdef BACKFACE_CULL_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                     s1_area_q <= '0;
        else if (!flush_i && s1_rdy && pop) s1_area_q <= area_d;
    end
`endif

    assign bbox_if.bbox_valid = out_vld_q;
    assign bbox_if.bbox_tri   = out_tri_q;
    assign bbox_if.bbox       = out_box_q;
    assign occupancy_o        = count;
    assign overflow_o         = overflow_q;
    assign drop_count_o       = drop_cnt_q;
endmodule

// File: tb/tb_triangle_bbox_stage.sv
// Bench for triangle_bbox_stage: directed and random triangles scored against an integer-arithmetic box model.
module tb_triangle_bbox_stage;
    import triangle_bbox_stage_pkg::*;

    localparam int DEPTH = 8;
    localparam int INFL  = 2;
`ifdef BACKFACE_CULL_EN
    localparam bit CULL = 1'b1;
`else
    localparam bit CULL = 1'b0;
`endif

    typedef struct packed { Triangle t; BBox b; } beat_t;

    logic        clk = 1'b0;
    logic        rst_n, flush, tri_in_valid, space_ready, overflow;
    Triangle     tri_in;
    logic [3:0]  occupancy;
    logic [15:0] drop_count;

    triangle_bbox_stage_if bif ();

    triangle_bbox_stage #(.FIFO_DEPTH(DEPTH), .INFLIGHT(INFL), .SCREEN_W(SCREEN_W), .SCREEN_H(SCREEN_H)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .flush_i       (flush),
        .tri_in_valid_i(tri_in_valid),
        .tri_in_i      (tri_in),
        .space_ready_o (space_ready),
        .bbox_if       (bif),
        .occupancy_o   (occupancy),
        .overflow_o    (overflow),
        .drop_count_o  (drop_count)
    );

    always #5 clk = ~clk;

    int    n_cmp = 0;
    int    n_bad = 0;
    int    exp_drops = 0;
    beat_t got[$];
    beat_t exp_q[$];

    function automatic int clip(input int v, input int hi);
        return (v < 0) ? 0 : ((v > hi) ? hi : v);
    endfunction

    // Reference: box and keep decision straight from the triangle's integer coordinates.
    function automatic void model(input Triangle t, output bit keep, output BBox b);
        int x[3], y[3];
        int xl, xh, yl, yh;
        longint area;
        for (int i = 0; i < 3; i++) begin
            x[i] = int'(t.v[i].x);
            y[i] = int'(t.v[i].y);
        end
        xl = x[0]; xh = x[0]; yl = y[0]; yh = y[0];
        for (int i = 1; i < 3; i++) begin
            if (x[i] < xl) xl = x[i];
            if (x[i] > xh) xh = x[i];
            if (y[i] < yl) yl = y[i];
            if (y[i] > yh) yh = y[i];
        end
        keep = !(xh < 0 || xl > SCREEN_W - 1 || yh < 0 || yl > SCREEN_H - 1);
        area = longint'(x[1] - x[0]) * longint'(y[2] - y[0]) - longint'(x[2] - x[0]) * longint'(y[1] - y[0]);
        if (CULL && area <= 0) keep = 1'b0;
        b.xmin = COORD_W'(clip(xl, SCREEN_W - 1));
        b.xmax = COORD_W'(clip(xh, SCREEN_W - 1));
        b.ymin = COORD_W'(clip(yl, SCREEN_H - 1));
        b.ymax = COORD_W'(clip(yh, SCREEN_H - 1));
    endfunction

    function automatic Triangle mk_tri(input int x0, input int y0, input int x1, input int y1, input int x2, input int y2);
        Triangle t;
        t.v[0].x = coord_t'(x0); t.v[0].y = coord_t'(y0);
        t.v[1].x = coord_t'(x1); t.v[1].y = coord_t'(y1);
        t.v[2].x = coord_t'(x2); t.v[2].y = coord_t'(y2);
        return t;
    endfunction

    function automatic Triangle rnd_tri();
        return mk_tri(int'($urandom_range(550)) - 100, int'($urandom_range(400)) - 80,
                      int'($urandom_range(550)) - 100, int'($urandom_range(400)) - 80,
                      int'($urandom_range(550)) - 100, int'($urandom_range(400)) - 80);
    endfunction

    // On-screen, counter-clockwise: kept in every build.
    function automatic Triangle kept_tri();
        int x0, y0;
        x0 = int'($urandom_range(250));
        y0 = int'($urandom_range(180));
        return mk_tri(x0, y0, x0 + int'($urandom_range(60, 1)), y0, x0, y0 + int'($urandom_range(50, 1)));
    endfunction

    task automatic model_push(input Triangle t);
        bit  k;
        BBox b;
        model(t, k, b);
        if (k) exp_q.push_back({t, b});
        else   exp_drops++;
    endtask

    // Inputs are set at the falling edge; a beat is taken if valid&&ready going into the rising edge.
    task automatic cycle();
        if (bif.bbox_valid && bif.bbox_ready) got.push_back({bif.bbox_tri, bif.bbox});
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst_n = 1'b0; flush = 1'b0; tri_in_valid = 1'b0; tri_in = '0; bif.bbox_ready = 1'b0;
        repeat (2) @(negedge clk);
        n_cmp++; if (bif.bbox_valid !== 1'b0) begin n_bad++; $display("FAIL reset_valid: got %b want 0", bif.bbox_valid); end
        n_cmp++; if (space_ready !== 1'b1) begin n_bad++; $display("FAIL reset_space: got %b want 1", space_ready); end
        n_cmp++; if (occupancy !== 4'd0 || overflow !== 1'b0 || drop_count !== 16'd0) begin
            n_bad++; $display("FAIL reset_status: occ %0d ovf %b drops %0d want 0 0 0", occupancy, overflow, drop_count); end
        rst_n = 1'b1;
        @(negedge clk);
        for (int i = 0; i < 4; i++) begin
            tri_in_valid = 1'b1; tri_in = mk_tri(10 + i, 10, 40, 10, 10, 40);
            cycle();
        end
        tri_in_valid = 1'b0;
        n_cmp++; if (bif.bbox_valid !== 1'b1 || occupancy !== 4'd1) begin
            n_bad++; $display("FAIL midstream_fill: valid %b occ %0d want 1 1", bif.bbox_valid, occupancy); end
        #2 rst_n = 1'b0;
        #1;
        n_cmp++; if (bif.bbox_valid !== 1'b0 || bif.bbox !== '0 || bif.bbox_tri !== '0) begin
            n_bad++; $display("FAIL midreset_out: valid %b box %h want 0 0", bif.bbox_valid, bif.bbox); end
        n_cmp++; if (space_ready !== 1'b1 || occupancy !== 4'd0) begin
            n_bad++; $display("FAIL midreset_fifo: space %b occ %0d want 1 0", space_ready, occupancy); end
        @(negedge clk);
        rst_n = 1'b1;
        got.delete(); exp_q.delete(); exp_drops = 0;
        @(negedge clk);
    endtask

    task automatic test_basic();
        BBox want;
        want.xmin = 12'd10; want.xmax = 12'd50; want.ymin = 12'd5; want.ymax = 12'd40;
        bif.bbox_ready = 1'b1;
        tri_in_valid = 1'b1; tri_in = mk_tri(10, 20, 50, 5, 30, 40);
        cycle();
        tri_in_valid = 1'b0;
        n_cmp++; if (occupancy !== 4'd1) begin n_bad++; $display("FAIL basic_occ: got %0d want 1", occupancy); end
        for (int k = 0; k < 3; k++) begin
            n_cmp++; if (bif.bbox_valid !== 1'b0) begin n_bad++; $display("FAIL basic_early t+%0d: got %b want 0", k, bif.bbox_valid); end
            if (k < 2) cycle();
        end
        cycle();
        n_cmp++; if (bif.bbox_valid !== 1'b1) begin n_bad++; $display("FAIL basic_latency: valid %b want 1 at t+3", bif.bbox_valid); end
        n_cmp++; if (bif.bbox !== want || bif.bbox_tri !== mk_tri(10, 20, 50, 5, 30, 40)) begin
            n_bad++; $display("FAIL basic_box: got %h want %h", bif.bbox, want); end
        cycle();
        got.delete(); exp_q.delete();
    endtask

    task automatic test_clamp();
        BBox want;
        want.xmin = 12'd0; want.xmax = 12'd319; want.ymin = 12'd0; want.ymax = 12'd239;
        bif.bbox_ready = 1'b1;
        tri_in_valid = 1'b1;
        tri_in = mk_tri(-5, -5, 400, 10, 20, 300);   model_push(tri_in); cycle();
        tri_in = mk_tri(-10, 0, -1, 0, -10, 9);      model_push(tri_in); cycle();
        tri_in = mk_tri(10, 250, 20, 250, 10, 260);  model_push(tri_in); cycle();
        tri_in_valid = 1'b0;
        repeat (8) cycle();
        n_cmp++; if (got.size() !== 1) begin n_bad++; $display("FAIL clamp_beats: got %0d want 1", got.size()); end
        if (got.size() > 0) begin
            n_cmp++; if (got[0].b !== want) begin n_bad++; $display("FAIL clamp_box: got %h want %h", got[0].b, want); end
        end
        n_cmp++; if (drop_count !== 16'(exp_drops)) begin n_bad++; $display("FAIL clamp_drops: got %0d want %0d", drop_count, exp_drops); end
        got.delete(); exp_q.delete();
    endtask

    task automatic test_random();
        Triangle fq[$];
        int      due[$];
        int      issued = 0, cyc = 0, max_occ = 0;
        bit      ovf_seen = 0;
        while ((issued < 150 || fq.size() > 0) && cyc < 3000) begin
            tri_in_valid = 1'b0;
            if (due.size() > 0 && due[0] == cyc) begin
                tri_in_valid = 1'b1; tri_in = fq.pop_front(); void'(due.pop_front()); model_push(tri_in);
            end
            if (issued < 150 && space_ready && $urandom_range(3) != 0) begin
                fq.push_back(rnd_tri()); due.push_back(cyc + INFL); issued++;
            end
            bif.bbox_ready = ($urandom_range(3) != 0);
            if (int'(occupancy) > max_occ) max_occ = int'(occupancy);
            if (overflow) ovf_seen = 1;
            cycle(); cyc++;
        end
        tri_in_valid = 1'b0; bif.bbox_ready = 1'b1;
        repeat (12) cycle();
        n_cmp++; if (cyc >= 3000) begin n_bad++; $display("FAIL random_budget: cycles %0d want < 3000", cyc); end
        n_cmp++; if (ovf_seen || max_occ > DEPTH) begin n_bad++; $display("FAIL random_credit: ovf %b max_occ %0d want 0 <=%0d", ovf_seen, max_occ, DEPTH); end
        n_cmp++; if (got.size() !== exp_q.size()) begin n_bad++; $display("FAIL random_count: got %0d want %0d", got.size(), exp_q.size()); end
        for (int i = 0; i < got.size() && i < exp_q.size(); i++) begin
            n_cmp++; if (got[i] !== exp_q[i]) begin n_bad++; $display("FAIL random_beat %0d: got %h want %h", i, got[i], exp_q[i]); end
        end
        n_cmp++; if (drop_count !== 16'(exp_drops)) begin n_bad++; $display("FAIL random_drops: got %0d want %0d", drop_count, exp_drops); end
        got.delete(); exp_q.delete();
    endtask

    task automatic test_backpressure();
        Triangle fq[$];
        int      due[$];
        int      issued = 0, cyc = 0, max_occ = 0;
        bit      ovf_seen = 0, stall_prev = 0;
        beat_t   held = '0;
        while ((issued < 20 || fq.size() > 0 || cyc < 60) && cyc < 800) begin
            if (stall_prev) begin
                n_cmp++; if (bif.bbox_valid !== 1'b1 || {bif.bbox_tri, bif.bbox} !== held) begin
                    n_bad++; $display("FAIL bp_stable cyc %0d: got %b/%h want 1/%h", cyc, bif.bbox_valid, bif.bbox, held.b); end
            end
            if (cyc == 59) begin
                n_cmp++; if (got.size() !== 0 || bif.bbox_valid !== 1'b1) begin
                    n_bad++; $display("FAIL bp_hold: beats %0d valid %b want 0 1", got.size(), bif.bbox_valid); end
            end
            tri_in_valid = 1'b0;
            if (due.size() > 0 && due[0] == cyc) begin
                tri_in_valid = 1'b1; tri_in = fq.pop_front(); void'(due.pop_front()); model_push(tri_in);
            end
            if (issued < 20 && space_ready) begin
                fq.push_back(kept_tri()); due.push_back(cyc + INFL); issued++;
            end
            bif.bbox_ready = (cyc < 60) ? 1'b0 : ($urandom_range(2) != 0);
            if (int'(occupancy) > max_occ) max_occ = int'(occupancy);
            if (overflow) ovf_seen = 1;
            stall_prev = bif.bbox_valid && !bif.bbox_ready;
            held = {bif.bbox_tri, bif.bbox};
            cycle(); cyc++;
        end
        tri_in_valid = 1'b0; bif.bbox_ready = 1'b1;
        repeat (12) cycle();
        n_cmp++; if (ovf_seen || max_occ > DEPTH) begin n_bad++; $display("FAIL bp_credit: ovf %b max_occ %0d want 0 <=%0d", ovf_seen, max_occ, DEPTH); end
        n_cmp++; if (got.size() !== 20) begin n_bad++; $display("FAIL bp_count: got %0d want 20", got.size()); end
        for (int i = 0; i < got.size() && i < exp_q.size(); i++) begin
            n_cmp++; if (got[i] !== exp_q[i]) begin n_bad++; $display("FAIL bp_order %0d: got %h want %h", i, got[i], exp_q[i]); end
        end
        got.delete(); exp_q.delete();
    endtask

    task automatic test_overflow_flush();
        bif.bbox_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin tri_in_valid = 1'b1; tri_in = kept_tri(); cycle(); end
        tri_in_valid = 1'b0;
        repeat (4) cycle();
        for (int i = 0; i < 8; i++) begin tri_in_valid = 1'b1; tri_in = kept_tri(); cycle(); end
        n_cmp++; if (occupancy !== 4'd8 || overflow !== 1'b0 || space_ready !== 1'b0) begin
            n_bad++; $display("FAIL ovf_full: occ %0d ovf %b space %b want 8 0 0", occupancy, overflow, space_ready); end
        tri_in = kept_tri(); cycle();
        tri_in_valid = 1'b0;
        n_cmp++; if (overflow !== 1'b1 || occupancy !== 4'd8) begin
            n_bad++; $display("FAIL ovf_ninth: ovf %b occ %0d want 1 8", overflow, occupancy); end
        cycle();
        n_cmp++; if (overflow !== 1'b1) begin n_bad++; $display("FAIL ovf_sticky: got %b want 1", overflow); end
        flush = 1'b1; tri_in_valid = 1'b1; tri_in = kept_tri();
        cycle();
        flush = 1'b0; tri_in_valid = 1'b0;
        n_cmp++; if (occupancy !== 4'd0 || overflow !== 1'b0 || bif.bbox_valid !== 1'b0) begin
            n_bad++; $display("FAIL flush_clear: occ %0d ovf %b valid %b want 0 0 0", occupancy, overflow, bif.bbox_valid); end
        n_cmp++; if (drop_count !== 16'(exp_drops)) begin n_bad++; $display("FAIL flush_drops: got %0d want %0d", drop_count, exp_drops); end
        got.delete(); exp_q.delete();
        bif.bbox_ready = 1'b1;
        tri_in_valid = 1'b1; tri_in = kept_tri(); model_push(tri_in); cycle();
        tri_in_valid = 1'b0;
        repeat (6) cycle();
        n_cmp++; if (got.size() !== 1 || (got.size() == 1 && got[0] !== exp_q[0])) begin
            n_bad++; $display("FAIL flush_recover: beats %0d want 1 matching model", got.size()); end
        got.delete(); exp_q.delete();
    endtask

    task automatic test_cull();
        int d0;
        d0 = exp_drops;
        bif.bbox_ready = 1'b1;
        tri_in_valid = 1'b1;
        tri_in = mk_tri(0, 0, 10, 0, 0, 10);   model_push(tri_in); cycle();
        tri_in = mk_tri(0, 0, 0, 10, 10, 0);   model_push(tri_in); cycle();
        tri_in = mk_tri(0, 0, 5, 5, 10, 10);   model_push(tri_in); cycle();
        tri_in_valid = 1'b0;
        repeat (8) cycle();
        n_cmp++; if (got.size() !== (CULL ? 1 : 3)) begin n_bad++; $display("FAIL cull_beats: got %0d want %0d", got.size(), CULL ? 1 : 3); end
        if (got.size() > 0) begin
            n_cmp++; if (got[0] !== exp_q[0]) begin n_bad++; $display("FAIL cull_ccw: got %h want %h", got[0], exp_q[0]); end
        end
        n_cmp++; if (drop_count !== 16'(d0 + (CULL ? 2 : 0))) begin
            n_bad++; $display("FAIL cull_drops: got %0d want %0d", drop_count, d0 + (CULL ? 2 : 0)); end
        got.delete(); exp_q.delete();
    endtask

    initial begin
        test_reset();
        test_basic();
        test_clamp();
        test_cull();
        test_random();
        test_backpressure();
        test_overflow_flush();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
